qpmm_batch_sequencer: RTL and testbench
=======================================

Name: qpmm_batch_sequencer

Overview:
- Drives a batch of modular multiplications through the QPMM pipeline.
- Issues read addresses to the two 272-bit operand RAMs (RAM0 feeds A, RAM1 feeds B) and tracks each operand pair through the fixed-latency multiplier.
- Writes every result Z back through the RAM write ports.
- It is the control and write-back end that the bare multiplier/RAM datapath lacks.

Parameters:
- DW, 272, operand/result width in bits
- AW, 8, RAM address width
- RAM_LAT, 2, cycles from addrb driven to doutb valid at multiplier input
- MUL_LAT, 24, cycles from A/B at multiplier input to Z valid

Ports:
- clk  in  1  single clock for RAMs, multiplier and sequencer
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, launches a batch; sampled only in IDLE
- src_a_base  in  AW  first RAM0 read address
- src_b_base  in  AW  first RAM1 read address
- dst_base  in  AW  first write address
- dst_sel  in  1  destination RAM: 0=RAM0, 1=RAM1
- count  in  AW+1  number of multiplications, 0..2^AW
- ram0_addrb  out  AW  RAM0 read address
- ram1_addrb  out  AW  RAM1 read address
- mul_z  in  DW  multiplier result
- ram_addra  out  AW  shared write address
- ram_dina  out  DW  shared write data
- ram0_wea  out  1  RAM0 write enable
- ram1_wea  out  1  RAM1 write enable
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the final result is written

Behaviour:
- Reset (rstn=0, asynchronous): all outputs 0, FSM to IDLE, valid pipe cleared, all counters 0.
- Start capture: on start in IDLE, latch all base inputs, dst_sel and count.
  - start while not in IDLE is ignored; no queuing.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start with count≠0 → ISSUE; busy=1 next cycle.
  - start with count=0 → DONE directly; no RAM access or write.
- ISSUE:
  - One read per cycle; ram0_addrb/ram1_addrb = base + issue index, both registered.
  - Inject a 1 into the valid pipe each cycle.
  - After count issues → DRAIN.
- Valid pipe: shift register, depth RAM_LAT+MUL_LAT. Its output marks mul_z valid; the multiplier has no valid of its own.
- Write-back:
  - When the pipe output is 1, register mul_z into ram_dina and assert the wea selected by dst_sel for exactly one cycle.
  - ram_addra = dst_base + write index.
  - Total latency: RAM_LAT+MUL_LAT+1 cycles from read-address issue to wea. Default: 27.
- DRAIN:
  - No new issues.
  - When the write index reaches count and the last write is asserted → DONE.
- DONE:
  - done=1 for one cycle; busy drops in the same cycle done is high.
  - → IDLE.
- Address arithmetic: modulo 2^AW; wrap past 2^AW−1 to 0 silently.
- count=2^AW: full 256 issues and 256 writes.
- Throughput: one result per cycle sustained; a batch of N takes N+27 cycles from start-accept to done (default parameters).
- In-place hazard: when the destination overlaps the sources, a read issued after a write to the same address sees the new value. The sequencer does not check this; software keeps regions disjoint or spaced by ≥27 entries.
- Idle outputs: wea deasserted in all non-write cycles; ram_dina holds its last value; read addresses hold their last value.
- Reset mid-batch: everything aborts immediately, with no further writes and no done. A start after reset release begins a fresh batch.

Test Plan:
- Reset → all outputs 0; IDLE; start=1 held during reset produces no activity after release until a new pulse.
- src_a=0x10, src_b=0x20, dst=0x40, dst_sel=1, count=4, multiplier model = A·B mod p → ram1_wea high cycles 27..30 after accept, addra 0x40..0x43, dina matches model; ram0_wea never high; done at cycle 31.
- count=0 → done two cycles after start, no wea, no address change, busy high for exactly one cycle.
- src_a=0xFE, count=4 → ram0_addrb sequence FE,FF,00,01; dst=0xFF gives addra FF,00,01,02.
- start pulsed again mid-batch (count=8) → ignored; exactly 8 writes, one done.
- rstn low at issue 3 of count=10 → wea never asserted afterward, no done; a new batch with count=2 then completes with exactly 2 correct writes.

Source files
------------

// File: rtl/qpmm_batch_sequencer.sv
// qpmm_batch_sequencer: issues operand reads for a batch of QPMM multiplications
// and writes each result back through the shared RAM write port.
module qpmm_batch_sequencer #(
  parameter int DW      = 272,
  parameter int AW      = 8,
  parameter int RAM_LAT = 2,
  parameter int MUL_LAT = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] src_a_base,
  input  logic [AW-1:0] src_b_base,
  input  logic [AW-1:0] dst_base,
  input  logic          dst_sel,
  input  logic [AW:0]   count,
  output logic [AW-1:0] ram0_addrb,
  output logic [AW-1:0] ram1_addrb,
  input  logic [DW-1:0] mul_z,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dina,
  output logic          ram0_wea,
  output logic          ram1_wea,
  output logic          busy,
  output logic          done
);
  localparam int PD = RAM_LAT + MUL_LAT;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic start_prev_q, start_prev_d, sel_q, sel_d, issue_v_q, issue_v_d;
  logic [AW-1:0] a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
  logic [AW:0] cnt_q, cnt_d, issue_idx_q, issue_idx_d, wr_idx_q, wr_idx_d;
  logic [PD-1:0] pipe_q, pipe_d;
  logic [AW-1:0] ram0_addrb_q, ram0_addrb_d, ram1_addrb_q, ram1_addrb_d, ram_addra_q, ram_addra_d;
  logic [DW-1:0] ram_dina_q, ram_dina_d;
  logic ram0_wea_q, ram0_wea_d, ram1_wea_q, ram1_wea_d, busy_q, busy_d, done_q, done_d;
  logic pipe_out;
  assign pipe_out = pipe_q[PD-1];
  always_comb begin
    state_d      = state_q;
    start_prev_d = start;
    sel_d        = sel_q;
    a_base_d     = a_base_q;
    b_base_d     = b_base_q;
    d_base_d     = d_base_q;
    cnt_d        = cnt_q;
    issue_idx_d  = issue_idx_q;
    wr_idx_d     = wr_idx_q;
    issue_v_d    = 1'b0;
    pipe_d       = {pipe_q[PD-2:0], issue_v_q};
    ram0_addrb_d = ram0_addrb_q;
    ram1_addrb_d = ram1_addrb_q;
    ram_addra_d  = ram_addra_q;
    ram_dina_d   = ram_dina_q;
    ram0_wea_d   = 1'b0;
    ram1_wea_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    if (pipe_out) begin
      ram_dina_d  = mul_z;
      ram_addra_d = d_base_q + wr_idx_q[AW-1:0];
      ram0_wea_d  = !sel_q;
      ram1_wea_d  = sel_q;
      wr_idx_d    = wr_idx_q + 1'b1;
    end
    case (state_q)
      IDLE: if (start && !start_prev_q) begin
        a_base_d = src_a_base;
        b_base_d = src_b_base;
        d_base_d = dst_base;
        sel_d    = dst_sel;
        cnt_d    = count;
        busy_d   = 1'b1;
        wr_idx_d = '0;
        if (count == '0) state_d = DONE;
        else begin
          ram0_addrb_d = src_a_base;
          ram1_addrb_d = src_b_base;
          issue_v_d    = 1'b1;
          issue_idx_d  = (AW+1)'(1);
          state_d      = (count == (AW+1)'(1)) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        ram0_addrb_d = a_base_q + issue_idx_q[AW-1:0];
        ram1_addrb_d = b_base_q + issue_idx_q[AW-1:0];
        issue_v_d    = 1'b1;
        issue_idx_d  = issue_idx_q + 1'b1;
        state_d      = (issue_idx_d == cnt_q) ? DRAIN : ISSUE;
      end
      DRAIN: state_d = (pipe_out && wr_idx_d == cnt_q) ? DONE : DRAIN;
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // start_prev resets high so a start held across reset release is not taken as a pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b1;
      sel_q        <= 1'b0;
      a_base_q     <= '0;
      b_base_q     <= '0;
      d_base_q     <= '0;
      cnt_q        <= '0;
      issue_idx_q  <= '0;
      wr_idx_q     <= '0;
      issue_v_q    <= 1'b0;
      pipe_q       <= '0;
      ram0_addrb_q <= '0;
      ram1_addrb_q <= '0;
      ram_addra_q  <= '0;
      ram_dina_q   <= '0;
      ram0_wea_q   <= 1'b0;
      ram1_wea_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      sel_q        <= sel_d;
      a_base_q     <= a_base_d;
      b_base_q     <= b_base_d;
      d_base_q     <= d_base_d;
      cnt_q        <= cnt_d;
      issue_idx_q  <= issue_idx_d;
      wr_idx_q     <= wr_idx_d;
      issue_v_q    <= issue_v_d;
      pipe_q       <= pipe_d;
      ram0_addrb_q <= ram0_addrb_d;
      ram1_addrb_q <= ram1_addrb_d;
      ram_addra_q  <= ram_addra_d;
      ram_dina_q   <= ram_dina_d;
      ram0_wea_q   <= ram0_wea_d;
      ram1_wea_q   <= ram1_wea_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end
  assign ram0_addrb = ram0_addrb_q;
  assign ram1_addrb = ram1_addrb_q;
  assign ram_addra  = ram_addra_q;
  assign ram_dina   = ram_dina_q;
  assign ram0_wea   = ram0_wea_q;
  assign ram1_wea   = ram1_wea_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_qpmm_batch_sequencer.sv
// tb_qpmm_batch_sequencer: drives batches against RAM/multiplier models and
// checks the write-back schedule, addresses and data against a cycle-indexed reference.
module tb_qpmm_batch_sequencer;
  localparam int DW = 272;
  localparam int MD = 26;
  localparam logic [DW-1:0] P = {1'b0, {(DW-1){1'b1}}} - 272'd18;
  logic clk = 0, rstn = 0, start = 1, dst_sel = 0;
  logic [7:0] src_a_base = 0, src_b_base = 0, dst_base = 0;
  logic [8:0] count = 0;
  logic [7:0] ram0_addrb, ram1_addrb, ram_addra;
  logic [DW-1:0] mul_z = 0, ram_dina;
  logic ram0_wea, ram1_wea, busy, done;
  logic [DW-1:0] ram0 [256];
  logic [DW-1:0] ram1 [256];
  logic [DW-1:0] mline [MD];
  logic [7:0] last_a = 0, last_b = 0, last_wa = 0;
  int checks = 0, errors = 0;

  qpmm_batch_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .src_a_base(src_a_base), .src_b_base(src_b_base),
    .dst_base(dst_base), .dst_sel(dst_sel), .count(count), .ram0_addrb(ram0_addrb),
    .ram1_addrb(ram1_addrb), .mul_z(mul_z), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram0_wea(ram0_wea), .ram1_wea(ram1_wea), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] modmul(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [2*DW-1:0] t;
    t = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
    t = t % {{DW{1'b0}}, P};
    return t[DW-1:0];
  endfunction

  // RAM read (2 cycles) plus multiplier (24 cycles) seen as one 26-cycle delay line
  always @(negedge clk) begin
    mul_z = mline[MD-1];
    for (int j = MD - 1; j > 0; j--) mline[j] = mline[j-1];
    mline[0] = modmul(ram0[ram0_addrb], ram1[ram1_addrb]);
  end

  task automatic run_batch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                           input logic sel, input int n, input int repulse);
    logic [7:0] ea, eb, ewa, k;
    logic [DW-1:0] edat;
    logic w, ebusy, edone;
    int writes = 0, dones = 0;
    @(negedge clk);
    src_a_base = a; src_b_base = b; dst_base = d; dst_sel = sel; count = n[8:0]; start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c <= n + 30; c++) begin
      if (c == repulse) begin start = 1; src_a_base = a + 8'd3; count = 9'd1; end
      else start = 0;
      ebusy = (n == 0) ? (c == 0) : (c < n + 27);
      edone = (n == 0) ? (c == 1) : (c == n + 27);
      ea = (n == 0) ? last_a : (c < n) ? a + 8'(c) : a + 8'(n - 1);
      eb = (n == 0) ? last_b : (c < n) ? b + 8'(c) : b + 8'(n - 1);
      w = (n > 0) && (c >= 27) && (c < 27 + n);
      k = 8'(c - 27);
      ewa = w ? d + k : last_wa;
      edat = modmul(ram0[a + k], ram1[b + k]);
      checks += 7;
      if (busy !== ebusy) begin errors++; $display("FAIL busy c=%0d got %b exp %b", c, busy, ebusy); end
      if (done !== edone) begin errors++; $display("FAIL done c=%0d got %b exp %b", c, done, edone); end
      if (ram0_addrb !== ea) begin errors++; $display("FAIL ram0_addrb c=%0d got %h exp %h", c, ram0_addrb, ea); end
      if (ram1_addrb !== eb) begin errors++; $display("FAIL ram1_addrb c=%0d got %h exp %h", c, ram1_addrb, eb); end
      if (ram0_wea !== (w && !sel)) begin errors++; $display("FAIL ram0_wea c=%0d got %b exp %b", c, ram0_wea, w && !sel); end
      if (ram1_wea !== (w && sel)) begin errors++; $display("FAIL ram1_wea c=%0d got %b exp %b", c, ram1_wea, w && sel); end
      if (ram_addra !== ewa) begin errors++; $display("FAIL ram_addra c=%0d got %h exp %h", c, ram_addra, ewa); end
      if (w) begin
        checks++;
        if (ram_dina !== edat) begin errors++; $display("FAIL ram_dina c=%0d got %h exp %h", c, ram_dina, edat); end
      end
      writes += int'(ram0_wea) + int'(ram1_wea);
      dones += int'(done);
      last_wa = ewa;
      @(negedge clk);
    end
    start = 0;
    checks += 2;
    if (writes != n) begin errors++; $display("FAIL write_count got %0d exp %0d", writes, n); end
    if (dones != 1) begin errors++; $display("FAIL done_count got %0d exp 1", dones); end
    if (n > 0) begin last_a = a + 8'(n - 1); last_b = b + 8'(n - 1); end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({busy, done, ram0_wea, ram1_wea, ram0_addrb, ram1_addrb, ram_addra, ram_dina} !== '0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b wea=%b%b ra=%h rb=%h wa=%h exp all zero", tag, busy, done,
               ram0_wea, ram1_wea, ram0_addrb, ram1_addrb, ram_addra);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rstn = 1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (busy !== 0 || ram0_wea !== 0 || ram1_wea !== 0) begin
        errors++; $display("FAIL held_start got busy=%b wea=%b%b exp 0", busy, ram0_wea, ram1_wea);
      end
    end
    start = 0;
  endtask

  task automatic test_basic();
    run_batch(8'h10, 8'h20, 8'h40, 1'b1, 4, -1);
  endtask

  task automatic test_zero_count();
    run_batch(8'h33, 8'h44, 8'h55, 1'b0, 0, -1);
  endtask

  task automatic test_wrap();
    run_batch(8'hFE, 8'h80, 8'hFF, 1'b0, 4, -1);
  endtask

  task automatic test_restart_ignored();
    run_batch(8'h01, 8'h61, 8'hC1, 1'b1, 8, 5);
  endtask

  task automatic test_abort();
    @(negedge clk);
    src_a_base = 8'h80; src_b_base = 8'h90; dst_base = 8'hA0; dst_sel = 0; count = 9'd10; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rstn = 0;
    #1 check_zero("abort_reset");
    @(negedge clk);
    rstn = 1;
    last_a = 0; last_b = 0; last_wa = 0;
    repeat (40) begin
      @(negedge clk);
      checks++;
      if (ram0_wea !== 0 || ram1_wea !== 0 || done !== 0 || busy !== 0) begin
        errors++; $display("FAIL after_abort got wea=%b%b done=%b busy=%b exp 0", ram0_wea, ram1_wea, done, busy);
      end
    end
    run_batch(8'h05, 8'h15, 8'hE0, 1'b1, 2, -1);
  endtask

  task automatic test_back_to_back();
    repeat (4) run_batch(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(1, 40), -1);
  endtask

  task automatic test_full();
    run_batch(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 256, -1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 9; j++) begin
        ram0[i] = {ram0[i][DW-33:0], 32'($urandom)};
        ram1[i] = {ram1[i][DW-33:0], 32'($urandom)};
      end
    for (int j = 0; j < MD; j++) mline[j] = '0;
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
    test_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
